// File: rtl/simple_axi_arbiter_if.sv
// Requester-side and master-side signal bundle of simple_axi_arbiter.
// The arbiter uses the slave modport; the environment uses the master modport.
interface simple_axi_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    i_req;
    logic [2*NUM_REQ-1:0]  i_req_rw;
    logic [3*NUM_REQ-1:0]  i_req_size;
    logic [32*NUM_REQ-1:0] i_req_addr;
    logic [64*NUM_REQ-1:0] i_req_wdata;
    logic [NUM_REQ-1:0]    o_ack;
    logic [63:0]           o_rdata;
    logic                  o_error;
    logic                  o_invalid;
    logic [NUM_REQ-1:0]    o_grant;
    logic                  o_busy;
    logic [1:0]            m_rw;
    logic [2:0]            m_size;
    logic [31:0]           m_addr;
    logic [63:0]           m_wdata;
    logic                  m_clear;
    logic                  m_wait;
    logic                  m_done;
    logic                  m_error;
    logic                  m_invalid;
    logic [63:0]           m_rdata;

    modport slave (
        input  i_req, i_req_rw, i_req_size, i_req_addr, i_req_wdata,
        input  m_wait, m_done, m_error, m_invalid, m_rdata,
        output o_ack, o_rdata, o_error, o_invalid, o_grant, o_busy,
        output m_rw, m_size, m_addr, m_wdata, m_clear
    );

    modport master (
        output i_req, i_req_rw, i_req_size, i_req_addr, i_req_wdata,
        output m_wait, m_done, m_error, m_invalid, m_rdata,
        input  o_ack, o_rdata, o_error, o_invalid, o_grant, o_busy,
        input  m_rw, m_size, m_addr, m_wdata, m_clear
    );
endinterface

// File: rtl/simple_axi_arbiter.sv
// Round-robin arbiter sharing one simple_axi_master port among NUM_REQ requesters:
// one command in flight, one-cycle ack with registered response, sticky flags cleared.
module simple_axi_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    simple_axi_arbiter_if.slave  bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [1:0]         rw_q, rw_d;
    logic [2:0]         size_q, size_d;
    logic [31:0]        addr_q, addr_d;
    logic [63:0]        wdata_q, wdata_d;
    logic [63:0]        rdata_q, rdata_d;
    logic               error_q, error_d;
    logic               invalid_q, invalid_d;

    logic [1:0]         req_rw_a    [NUM_REQ];
    logic [2:0]         req_size_a  [NUM_REQ];
    logic [31:0]        req_addr_a  [NUM_REQ];
    logic [63:0]        req_wdata_a [NUM_REQ];

    logic [IDX_W:0]     pick_s;
    logic               pick_vld_s;
    logic [IDX_W-1:0]   pick_idx_s;
    logic [1:0]         m_rw_s;
    logic               m_clear_s;
    logic [NUM_REQ-1:0] idx_oh_s;

    // First requesting index at or above ptr, wrapping; MSB flags a hit.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] pos_idx;
        int               pos;
        res = {(IDX_W+1){1'b0}};
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos     = int'(ptr) + k;
            pos     = (pos >= NUM_REQ) ? (pos - NUM_REQ) : pos;
            pos_idx = IDX_W'(pos);
            if (req[pos_idx]) begin
                res = {1'b1, pos_idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    for (genvar r = 0; r < NUM_REQ; r++) begin : g_unpack
        assign req_rw_a[r]    = bus.i_req_rw[2*r +: 2];
        assign req_size_a[r]  = bus.i_req_size[3*r +: 3];
        assign req_addr_a[r]  = bus.i_req_addr[32*r +: 32];
        assign req_wdata_a[r] = bus.i_req_wdata[64*r +: 64];
    end

    assign pick_s     = rr_pick(bus.i_req, ptr_q);
    assign pick_vld_s = pick_s[IDX_W];
    assign pick_idx_s = pick_s[IDX_W-1:0];
    assign idx_oh_s   = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx_q;

    // Next-state, command latch, response capture and master strobes.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        rw_d      = rw_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        error_d   = error_q;
        invalid_d = invalid_q;
        m_rw_s    = 2'b00;
        m_clear_s = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (pick_vld_s) begin
                    idx_d   = pick_idx_s;
                    rw_d    = req_rw_a[pick_idx_s];
                    size_d  = req_size_a[pick_idx_s];
                    addr_d  = req_addr_a[pick_idx_s];
                    wdata_d = req_wdata_a[pick_idx_s];
                    // Undefined rw codes never reach the master.
                    if ((req_rw_a[pick_idx_s] == 2'b00) || (req_rw_a[pick_idx_s] == 2'b11)) begin
                        rdata_d   = 64'd0;
                        error_d   = 1'b1;
                        invalid_d = 1'b1;
                        state_d   = S_RESP;
                    end else begin
                        state_d   = S_ISSUE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                m_rw_s    = rw_q;
                m_clear_s = bus.m_done;
                if (bus.m_done) begin
                    rdata_d   = 64'd0;
                    error_d   = bus.m_error;
                    invalid_d = bus.m_invalid;
                    state_d   = S_RESP;
                end else begin
                    state_d   = S_BUSY;
                end
            end
            S_BUSY: begin
                if (bus.m_done && !bus.m_wait) begin
                    m_clear_s = 1'b1;
                    rdata_d   = (rw_q == 2'b10) ? bus.m_rdata : 64'd0;
                    error_d   = bus.m_error;
                    invalid_d = bus.m_invalid;
                    state_d   = S_RESP;
                end else begin
                    m_clear_s = 1'b0;
                    state_d   = S_BUSY;
                end
            end
            S_RESP: begin
                ptr_d   = (idx_q == IDX_W'(NUM_REQ - 1)) ? {IDX_W{1'b0}} : (idx_q + IDX_W'(1));
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= {IDX_W{1'b0}};
            idx_q     <= {IDX_W{1'b0}};
            rw_q      <= 2'b00;
            size_q    <= 3'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 64'd0;
            rdata_q   <= 64'd0;
            error_q   <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            rw_q      <= rw_d;
            size_q    <= size_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            error_q   <= error_d;
            invalid_q <= invalid_d;
        end
    end

    assign bus.o_ack     = (state_q == S_RESP) ? idx_oh_s : {NUM_REQ{1'b0}};
    assign bus.o_grant   = (state_q != S_IDLE) ? idx_oh_s : {NUM_REQ{1'b0}};
    assign bus.o_busy    = (state_q != S_IDLE);
    assign bus.o_rdata   = rdata_q;
    assign bus.o_error   = error_q;
    assign bus.o_invalid = invalid_q;
    assign bus.m_rw      = m_rw_s;
    assign bus.m_size    = size_q;
    assign bus.m_addr    = addr_q;
    assign bus.m_wdata   = wdata_q;
    assign bus.m_clear   = m_clear_s;
endmodule

// File: tb/tb_simple_axi_arbiter.sv
// Directed table-driven bench for simple_axi_arbiter (NUM_REQ=4), plus a
// hand-written round-robin contention sequence.
module tb_simple_axi_arbiter;
    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    simple_axi_arbiter_if #(.NUM_REQ(4)) bus ();

    simple_axi_arbiter #(.NUM_REQ(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [7:0]  rw;
        logic [11:0] size;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic        mwait;
        logic        mdone;
        logic        merr;
        logic        minv;
        logic [63:0] mrdata;
        logic [3:0]  ack;
        logic [3:0]  grant;
        logic        busy;
        logic [1:0]  mrw;
        logic        clear;
        logic [63:0] rdata;
        logic        err;
        logic        inv;
    } vec_t;

    localparam int NV = 27;
    vec_t tbl [NV];

    // cmd: 0 aligned read, 1 misaligned write, 2 aligned 8-byte write, 3 bad rw
    function automatic vec_t v(input logic r, input logic [3:0] req, input int cmd,
                               input logic mwait, input logic mdone, input logic merr,
                               input logic minv, input logic [63:0] mrdata,
                               input logic [3:0] ack, input logic [3:0] grant,
                               input logic busy, input logic [1:0] mrw, input logic clear,
                               input logic [63:0] rdata, input logic err, input logic inv);
        vec_t t;
        t.rst = r; t.req = req;
        case (cmd)
            0:       begin t.rw = 8'hAA; t.size = 12'h492; t.addr = 32'h0000_1004; t.wdata = 64'd0; end
            1:       begin t.rw = 8'h55; t.size = 12'h249; t.addr = 32'h0000_0003; t.wdata = 64'd0; end
            2:       begin t.rw = 8'h55; t.size = 12'h6DB; t.addr = 32'h0000_0008; t.wdata = 64'h0123_4567_89AB_CDEF; end
            default: begin t.rw = 8'hFF; t.size = 12'h000; t.addr = 32'h0000_0000; t.wdata = 64'd0; end
        endcase
        t.mwait = mwait; t.mdone = mdone; t.merr = merr; t.minv = minv; t.mrdata = mrdata;
        t.ack = ack; t.grant = grant; t.busy = busy; t.mrw = mrw; t.clear = clear;
        t.rdata = rdata; t.err = err; t.inv = inv;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    localparam logic [63:0] DB = 64'h0000_0000_DEAD_BEEF;
    localparam logic [63:0] FF = 64'hFFFF_FFFF_FFFF_FFFF;

    logic [3:0] exp_oh;
    int         ack_cnt [4];

    initial begin
        n_pass = 0;
        n_total = 0;
        rst = 1'b1;
        bus.i_req = 4'b0000; bus.i_req_rw = 8'h00; bus.i_req_size = 12'h000;
        bus.i_req_addr = 128'd0; bus.i_req_wdata = 256'd0;
        bus.m_wait = 1'b0; bus.m_done = 1'b0; bus.m_error = 1'b0;
        bus.m_invalid = 1'b0; bus.m_rdata = 64'd0;
        repeat (3) @(posedge clk);

        //           rst   req     c  wait done err  inv  mrdata ack     grant   busy mrw    clr  rdata err  inv
        tbl[0]  = v(1'b1, 4'b0000, 0, 1'b0,1'b0,1'b0,1'b0, 64'd0, 4'b0000,4'b0000,1'b0,2'b00,1'b1, 64'd0,1'b0,1'b0);
        tbl[1]  = v(1'b0, 4'b0010, 0, 1'b0,1'b0,1'b0,1'b0, 64'd0, 4'b0000,4'b0000,1'b0,2'b00,1'b1, 64'd0,1'b0,1'b0);
        tbl[2]  = v(1'b0, 4'b0010, 0, 1'b0,1'b0,1'b0,1'b0, 64'd0, 4'b0000,4'b0010,1'b1,2'b10,1'b0, 64'd0,1'b0,1'b0);
        tbl[3]  = v(1'b0, 4'b0010, 0, 1'b1,1'b0,1'b0,1'b0, 64'd0, 4'b0000,4'b0010,1'b1,2'b00,1'b0, 64'd0,1'b0,1'b0);
        tbl[4]  = v(1'b0, 4'b0010, 0, 1'b0,1'b1,1'b0,1'b0, DB,    4'b0000,4'b0010,1'b1,2'b00,1'b1, 64'd0,1'b0,1'b0);
        tbl[5]  = v(1'b0, 4'b0010, 0, 1'b0,1'b1,1'b0,1'b0, DB,    4'b0010,4'b0010,1'b1,2'b00,1'b1, DB,   1'b0,1'b0);
        tbl[6]  = v(1'b0, 4'b0000, 0, 1'b0,1'b0,1'b0,1'b0, 64'd0, 4'b0000,4'b0000,1'b0,2'b00,1'b1, DB,   1'b0,1'b0);
        tbl[7]  = v(1'b0, 4'b0100, 1, 1'b0,1'b0,1'b0,1'b0, 64'd0, 4'b0000,4'b0000,1'b0,2'b00,1'b1, DB,   1'b0,1'b0);
        tbl[8]  = v(1'b0, 4'b0100, 1, 1'b0,1'b1,1'b1,1'b1, 64'd0, 4'b0000,4'b0100,1'b1,2'b01,1'b1, DB,   1'b0,1'b0);
        tbl[9]  = v(1'b0, 4'b0100, 1, 1'b0,1'b1,1'b1,1'b1, 64'd0, 4'b0100,4'b0100,1'b1,2'b00,1'b1, 64'd0,1'b1,1'b1);
        tbl[10] = v(1'b0, 4'b0000, 1, 1'b0,1'b0,1'b0,1'b0, 64'd0, 4'b0000,4'b0000,1'b0,2'b00,1'b1, 64'd0,1'b1,1'b1);
        tbl[11] = v(1'b0, 4'b0001, 2, 1'b0,1'b0,1'b0,1'b0, 64'd0, 4'b0000,4'b0000,1'b0,2'b00,1'b1, 64'd0,1'b1,1'b1);
        tbl[12] = v(1'b0, 4'b0001, 2, 1'b0,1'b0,1'b0,1'b0, 64'd0, 4'b0000,4'b0001,1'b1,2'b01,1'b0, 64'd0,1'b1,1'b1);
        tbl[13] = v(1'b0, 4'b0001, 2, 1'b1,1'b0,1'b0,1'b0, 64'd0, 4'b0000,4'b0001,1'b1,2'b00,1'b0, 64'd0,1'b1,1'b1);
        tbl[14] = v(1'b0, 4'b0001, 2, 1'b0,1'b1,1'b1,1'b0, FF,    4'b0000,4'b0001,1'b1,2'b00,1'b1, 64'd0,1'b1,1'b1);
        tbl[15] = v(1'b0, 4'b0001, 2, 1'b0,1'b1,1'b1,1'b0, FF,    4'b0001,4'b0001,1'b1,2'b00,1'b1, 64'd0,1'b1,1'b0);
        tbl[16] = v(1'b0, 4'b0000, 2, 1'b0,1'b0,1'b0,1'b0, 64'd0, 4'b0000,4'b0000,1'b0,2'b00,1'b1, 64'd0,1'b1,1'b0);
        tbl[17] = v(1'b0, 4'b1000, 3, 1'b0,1'b0,1'b0,1'b0, 64'd0, 4'b0000,4'b0000,1'b0,2'b00,1'b1, 64'd0,1'b1,1'b0);
        tbl[18] = v(1'b0, 4'b1000, 3, 1'b0,1'b0,1'b0,1'b0, 64'd0, 4'b1000,4'b1000,1'b1,2'b00,1'b1, 64'd0,1'b1,1'b1);
        tbl[19] = v(1'b0, 4'b0000, 3, 1'b0,1'b0,1'b0,1'b0, 64'd0, 4'b0000,4'b0000,1'b0,2'b00,1'b1, 64'd0,1'b1,1'b1);
        tbl[20] = v(1'b0, 4'b0010, 0, 1'b0,1'b0,1'b0,1'b0, 64'd0, 4'b0000,4'b0000,1'b0,2'b00,1'b1, 64'd0,1'b1,1'b1);
        tbl[21] = v(1'b0, 4'b0010, 0, 1'b0,1'b0,1'b0,1'b0, 64'd0, 4'b0000,4'b0010,1'b1,2'b10,1'b0, 64'd0,1'b1,1'b1);
        tbl[22] = v(1'b0, 4'b0010, 0, 1'b1,1'b0,1'b0,1'b0, 64'd0, 4'b0000,4'b0010,1'b1,2'b00,1'b0, 64'd0,1'b1,1'b1);
        tbl[23] = v(1'b1, 4'b0010, 0, 1'b1,1'b0,1'b0,1'b0, 64'd0, 4'b0000,4'b0010,1'b1,2'b00,1'b0, 64'd0,1'b1,1'b1);
        tbl[24] = v(1'b0, 4'b0000, 0, 1'b0,1'b0,1'b0,1'b0, 64'd0, 4'b0000,4'b0000,1'b0,2'b00,1'b1, 64'd0,1'b0,1'b0);
        tbl[25] = v(1'b0, 4'b0000, 0, 1'b0,1'b0,1'b0,1'b0, 64'd0, 4'b0000,4'b0000,1'b0,2'b00,1'b1, 64'd0,1'b0,1'b0);
        tbl[26] = v(1'b0, 4'b0000, 0, 1'b0,1'b0,1'b0,1'b0, 64'd0, 4'b0000,4'b0000,1'b0,2'b00,1'b1, 64'd0,1'b0,1'b0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst               = tbl[i].rst;
            bus.i_req         = tbl[i].req;
            bus.i_req_rw      = tbl[i].rw;
            bus.i_req_size    = tbl[i].size;
            bus.i_req_addr    = {4{tbl[i].addr}};
            bus.i_req_wdata   = {4{tbl[i].wdata}};
            bus.m_wait        = tbl[i].mwait;
            bus.m_done        = tbl[i].mdone;
            bus.m_error       = tbl[i].merr;
            bus.m_invalid     = tbl[i].minv;
            bus.m_rdata       = tbl[i].mrdata;
            #1;
            chk($sformatf("row%0d.ack", i),     64'(bus.o_ack),     64'(tbl[i].ack));
            chk($sformatf("row%0d.grant", i),   64'(bus.o_grant),   64'(tbl[i].grant));
            chk($sformatf("row%0d.busy", i),    64'(bus.o_busy),    64'(tbl[i].busy));
            chk($sformatf("row%0d.m_rw", i),    64'(bus.m_rw),      64'(tbl[i].mrw));
            chk($sformatf("row%0d.m_clear", i), 64'(bus.m_clear),   64'(tbl[i].clear));
            chk($sformatf("row%0d.rdata", i),   bus.o_rdata,        tbl[i].rdata);
            chk($sformatf("row%0d.error", i),   64'(bus.o_error),   64'(tbl[i].err));
            chk($sformatf("row%0d.invalid", i), 64'(bus.o_invalid), 64'(tbl[i].inv));
            if (i == 12) begin
                chk("slverr.m_addr",  64'(bus.m_addr), 64'h8);
                chk("slverr.m_size",  64'(bus.m_size), 64'd3);
                chk("slverr.m_wdata", bus.m_wdata,     64'h0123_4567_89AB_CDEF);
            end
        end

        // Contention: all four requesters held, pointer at 0 after reset.
        bus.i_req_rw    = 8'hAA;
        bus.i_req_size  = 12'h492;
        bus.i_req_addr  = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100, 32'h0000_0000};
        bus.i_req_wdata = {64'h33, 64'h22, 64'h11, 64'h00};
        for (int k = 0; k < 4; k++) ack_cnt[k] = 0;
        for (int g = 0; g < 5; g++) begin
            exp_oh = 4'b0001 << (g % 4);
            @(negedge clk);
            bus.i_req = 4'b1111; bus.m_done = 1'b0; bus.m_wait = 1'b0;
            bus.m_error = 1'b0; bus.m_invalid = 1'b0;
            #1;
            chk($sformatf("cont%0d.idle_grant", g), 64'(bus.o_grant), 64'd0);
            @(negedge clk);
            #1;
            chk($sformatf("cont%0d.grant", g),  64'(bus.o_grant), 64'(exp_oh));
            chk($sformatf("cont%0d.m_rw", g),   64'(bus.m_rw),    64'd2);
            chk($sformatf("cont%0d.m_addr", g), 64'(bus.m_addr),  64'((g % 4) * 256));
            chk($sformatf("cont%0d.m_wdata", g), bus.m_wdata,     64'((g % 4) * 17));
            @(negedge clk);
            bus.m_done = 1'b1; bus.m_rdata = 64'(100 + g);
            #1;
            chk($sformatf("cont%0d.m_clear", g), 64'(bus.m_clear), 64'd1);
            @(negedge clk);
            #1;
            chk($sformatf("cont%0d.ack", g),   64'(bus.o_ack), 64'(exp_oh));
            chk($sformatf("cont%0d.rdata", g), bus.o_rdata,    64'(100 + g));
            for (int k = 0; k < 4; k++) ack_cnt[k] += int'(bus.o_ack[k]);
        end
        @(negedge clk);
        bus.i_req = 4'b0000; bus.m_done = 1'b0;
        chk("cont.acks0", 64'(ack_cnt[0]), 64'd2);
        chk("cont.acks1", 64'(ack_cnt[1]), 64'd1);
        chk("cont.acks2", 64'(ack_cnt[2]), 64'd1);
        chk("cont.acks3", 64'(ack_cnt[3]), 64'd1);
        @(negedge clk);
        #1;
        chk("final.busy", 64'(bus.o_busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/simple_axi_arbiter.md
Name: simple_axi_arbiter

Overview:
- Round-robin arbiter sharing one simple_axi_master user port among NUM_REQ requesters.
- Each requester holds a valid-until-ack command.
- The arbiter issues exactly one command at a time to the master and waits for its completion.
- It returns read data and status to the winning requester with a one-cycle ack, then clears the master's sticky done/error flags.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDX_W, $clog2(NUM_REQ), grant index width (derived; do not override).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset. System drives the master's i_rstn from ~i_rst.
- i_req  in  NUM_REQ  per-requester request. Held high, with the command stable, until the matching o_ack.
- i_req_rw  in  2*NUM_REQ  per-requester command: 01 write, 10 read.
- i_req_size  in  3*NUM_REQ  per-requester size code, 0..3.
- i_req_addr  in  32*NUM_REQ  per-requester byte address.
- i_req_wdata  in  64*NUM_REQ  per-requester right-aligned write data.
- o_ack  out  NUM_REQ  one-hot, single-cycle completion pulse.
- o_rdata  out  64  read data, valid with o_ack; 0 for writes.
- o_error  out  1  valid with o_ack.
- o_invalid  out  1  valid with o_ack.
- o_grant  out  NUM_REQ  one-hot owner, non-zero from ISSUE through RESP.
- o_busy  out  1  high whenever state != IDLE.
- m_rw  out  2  to master i_rw.
- m_size  out  3  to master i_size.
- m_addr  out  32  to master i_addr.
- m_wdata  out  64  to master i_wdata.
- m_clear  out  1  to master i_clear.
- m_wait  in  1  from master o_wait.
- m_done  in  1  from master o_done.
- m_error  in  1  from master o_error.
- m_invalid  in  1  from master o_invalid.
- m_rdata  in  64  from master o_rdata.

Behaviour:
- Reset (i_rst=1 at posedge) values:
  - state=IDLE, rr pointer=0, latched command=0.
  - o_ack=0, o_rdata=0, o_error=0, o_invalid=0, o_grant=0, o_busy=0, m_rw=00, m_clear=1.
  - Reset mid-transaction abandons it with no ack; requesters must re-request.
- States: IDLE, ISSUE, BUSY, RESP.
- IDLE:
  - m_rw=00, m_clear=1.
  - If any i_req is set, select the first set bit searching from the pointer upward, wrapping at NUM_REQ-1 to 0.
  - Latch its rw/size/addr/wdata and index, then go to ISSUE.
  - If the latched rw is 00 or 11, go directly to RESP with error=1, invalid=1, rdata=0, and never drive the master.
- ISSUE (exactly one cycle):
  - m_rw/m_size/m_addr/m_wdata driven from latched registers; m_clear=0.
  - If m_done=1 in this cycle (master rejected a misaligned request), capture m_error/m_invalid with rdata=0, assert m_clear=1, and go to RESP.
  - Otherwise go to BUSY.
- BUSY:
  - m_rw=00; m_addr/m_size/m_wdata stay at latched values.
  - m_clear=0 until completion.
  - On the cycle m_done=1 and m_wait=0:
    - capture m_rdata (0 if the command was a write), m_error and m_invalid;
    - assert m_clear=1 in that same cycle, so the master returns to S_IDLE;
    - go to RESP.
  - There is no timeout; BUSY persists as long as the master waits.
- RESP (one cycle):
  - o_ack[idx]=1 with registered o_rdata/o_error/o_invalid; m_clear=1.
  - Pointer <= (idx+1) mod NUM_REQ; go to IDLE.
  - o_rdata/o_error/o_invalid hold their value until the next RESP.
- Latency:
  - Misaligned or bad-rw request: req seen in cycle 0, ack in cycle 2 (bad rw: ack in cycle 1).
  - Otherwise: ack one cycle after the master completes.
  - Back-to-back grants: at least one IDLE cycle between RESP and the next ISSUE.
- Fairness: each requester is served within NUM_REQ grants of first asserting i_req.
- A requester's i_req deasserting while it is not granted is legal. Deasserting while granted is a protocol violation; the latched command still completes.
- o_grant is the one-hot decode of idx in ISSUE/BUSY/RESP and 0 in IDLE.

Test Plan:
- Single read: req[1], rw=10, addr=0x1004, size=2; master model returns 0x00000000_DEADBEEF, rresp=OKAY -> one ISSUE cycle with m_rw=10; o_ack=0010, o_rdata=0xDEADBEEF, o_error=0; m_clear=1 at completion.
- Contention: req=1111 held, pointer=0 -> grants in order 0,1,2,3,0; no requester is acked twice before the others are each acked once.
- Misaligned write: req[2], rw=01, addr=0x3, size=1 -> master flags done/error/invalid in ISSUE; o_ack=0100 two cycles after req, o_error=1, o_invalid=1; no AXI AW activity.
- Write with SLVERR: req[0], rw=01, addr=0x8, size=3, wdata=0x0123456789ABCDEF -> o_ack=0001, o_error=1, o_invalid=0, o_rdata=0; m_done low the cycle after RESP.
- Bad command: req[3] with rw=11 -> o_ack=1000 one cycle later with error=1 and invalid=1; m_rw stays 00 throughout.
- Reset in BUSY: assert i_rst while a read is waiting on rvalid -> next cycle all outputs are at reset values and state is IDLE; with no requests pending afterwards, no o_ack pulse appears.
